// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the multiply issue controller: the M-extension opcode
// match/mask constants and the scoreboard entry type.
package mul_issue_ctrl_pkg;

    localparam logic [31:0] INST_MUL        = 32'h0200_0033;
    localparam logic [31:0] INST_MUL_MASK   = 32'hfe00_707f;
    localparam logic [31:0] INST_MULH       = 32'h0200_1033;
    localparam logic [31:0] INST_MULH_MASK  = 32'hfe00_707f;
    localparam logic [31:0] INST_MULHSU     = 32'h0200_2033;
    localparam logic [31:0] INST_MULHSU_MASK = 32'hfe00_707f;
    localparam logic [31:0] INST_MULHU      = 32'h0200_3033;
    localparam logic [31:0] INST_MULHU_MASK = 32'hfe00_707f;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } sb_entry_t;

    function automatic logic is_mul_op(input logic [31:0] op);
        return ((op & INST_MUL_MASK)    == INST_MUL)    ||
               ((op & INST_MULH_MASK)   == INST_MULH)   ||
               ((op & INST_MULHSU_MASK) == INST_MULHSU) ||
               ((op & INST_MULHU_MASK)  == INST_MULHU);
    endfunction

endpackage

// File: rtl/mul_sb_entry_cmp.sv
// One scoreboard stage: holds an in-flight {v, rd} and compares it against the
// sources and destination of the instruction in the issue slot.
module mul_sb_entry_cmp
    import mul_issue_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hold_i,
    input  sb_entry_t  d,
    output sb_entry_t  q,
    input  logic [4:0] ra_idx,
    input  logic [4:0] rb_idx,
    input  logic [4:0] rd_idx,
    output logic       ra_hit,
    output logic       rb_hit,
    output logic       waw_hit
);

    logic live;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            q <= '0;
        else if (!hold_i)
            q <= d;
    end

    // x0 never carries a result, so it can never create a dependency
    assign live    = q.v & (q.rd != 5'd0);
    assign ra_hit  = live & (q.rd == ra_idx);
    assign rb_hit  = live & (q.rd == rb_idx);
    assign waw_hit = live & (q.rd == rd_idx);

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue-side controller for the pipelined multiplier: decode, hazard stall and
// writeback tracking. Optional feature macro: MUL_BYPASS_EN (writeback-stage bypass).
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int MULT_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hold_i,
    input  logic        issue_valid_i,
    input  logic [31:0] issue_opcode_i,
    input  logic        issue_invalid_i,
    input  logic [4:0]  issue_rd_idx_i,
    input  logic [4:0]  issue_ra_idx_i,
    input  logic [4:0]  issue_rb_idx_i,
    output logic        issue_stall_o,
    output logic        mul_valid_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [1:0]  inflight_o
`ifdef MUL_BYPASS_EN
    ,
    output logic        bypass_ra_o,
    output logic        bypass_rb_o
`endif
);

    localparam int LAST = MULT_STAGES - 1;

`ifdef MUL_BYPASS_EN
    // The writeback stage value is forwarded, so it no longer blocks readers
    localparam logic [MULT_STAGES-1:0] RAW_MASK = {1'b0, {(MULT_STAGES-1){1'b1}}};
`else
    localparam logic [MULT_STAGES-1:0] RAW_MASK = {MULT_STAGES{1'b1}};
`endif

    sb_entry_t               sb_d [MULT_STAGES];
    sb_entry_t               sb_q [MULT_STAGES];
    logic [MULT_STAGES-1:0]  ra_hit;
    logic [MULT_STAGES-1:0]  rb_hit;
    logic [MULT_STAGES-1:0]  waw_hit;
    logic [MULT_STAGES-1:0]  v_vec;
    logic                    mul_w;
    logic [1:0]              cnt;

    assign mul_w = issue_valid_i & ~issue_invalid_i & is_mul_op(issue_opcode_i);

    genvar g;
    generate
        for (g = 0; g < MULT_STAGES; g++) begin : g_sb
            if (g == 0) begin : g_head
                assign sb_d[g] = '{v: mul_valid_o & (issue_rd_idx_i != 5'd0),
                                   rd: issue_rd_idx_i};
            end else begin : g_shift
                assign sb_d[g] = sb_q[g-1];
            end

            mul_sb_entry_cmp u_entry (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .hold_i  (hold_i),
                .d       (sb_d[g]),
                .q       (sb_q[g]),
                .ra_idx  (issue_ra_idx_i),
                .rb_idx  (issue_rb_idx_i),
                .rd_idx  (issue_rd_idx_i),
                .ra_hit  (ra_hit[g]),
                .rb_hit  (rb_hit[g]),
                .waw_hit (waw_hit[g])
            );

            assign v_vec[g] = sb_q[g].v;
        end
    endgenerate

    // Stall never depends on mul_valid_o, which keeps the issue path loop-free
    assign issue_stall_o = issue_valid_i &
                           ((|((ra_hit | rb_hit) & RAW_MASK)) | (|waw_hit));
    assign mul_valid_o   = mul_w & ~issue_stall_o & ~hold_i;

    assign wb_valid_o    = sb_q[LAST].v;
    assign wb_rd_idx_o   = sb_q[LAST].rd;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < MULT_STAGES; i++)
            cnt = cnt + {1'b0, v_vec[i]};
    end
    assign inflight_o = cnt;

`ifdef MUL_BYPASS_EN
    assign bypass_ra_o = ra_hit[LAST];
    assign bypass_rb_o = rb_hit[LAST];
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed self-checking bench for mul_issue_ctrl with MULT_STAGES=2; handles
// both the default and the MUL_BYPASS_EN build.
module tb_mul_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        hold_i;
    logic        issue_valid_i;
    logic [31:0] issue_opcode_i;
    logic        issue_invalid_i;
    logic [4:0]  issue_rd_idx_i;
    logic [4:0]  issue_ra_idx_i;
    logic [4:0]  issue_rb_idx_i;
    logic        issue_stall_o;
    logic        mul_valid_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_idx_o;
    logic [1:0]  inflight_o;
`ifdef MUL_BYPASS_EN
    logic        bypass_ra_o;
    logic        bypass_rb_o;
`endif

    int checks = 0;
    int failures = 0;

    mul_issue_ctrl #(.MULT_STAGES(2)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .hold_i          (hold_i),
        .issue_valid_i   (issue_valid_i),
        .issue_opcode_i  (issue_opcode_i),
        .issue_invalid_i (issue_invalid_i),
        .issue_rd_idx_i  (issue_rd_idx_i),
        .issue_ra_idx_i  (issue_ra_idx_i),
        .issue_rb_idx_i  (issue_rb_idx_i),
        .issue_stall_o   (issue_stall_o),
        .mul_valid_o     (mul_valid_o),
        .wb_valid_o      (wb_valid_o),
        .wb_rd_idx_o     (wb_rd_idx_o),
        .inflight_o      (inflight_o)
`ifdef MUL_BYPASS_EN
        ,
        .bypass_ra_o     (bypass_ra_o),
        .bypass_rb_o     (bypass_rb_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] ra,
                                         input logic [4:0] rb);
        return {f7, rb, ra, f3, rd, 7'b0110011};
    endfunction

    // Sets the issue slot; the opcode fields and the index ports agree
    task automatic issue_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [4:0] ra, input logic [4:0] rb, input logic inv);
        issue_valid_i   = 1'b1;
        issue_opcode_i  = r_op(f7, f3, rd, ra, rb);
        issue_invalid_i = inv;
        issue_rd_idx_i  = rd;
        issue_ra_idx_i  = ra;
        issue_rb_idx_i  = rb;
    endtask

    task automatic mul(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb);
        issue_r(7'h01, 3'd0, rd, ra, rb, 1'b0);
    endtask

    task automatic add(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb);
        issue_r(7'h00, 3'd0, rd, ra, rb, 1'b0);
    endtask

    task automatic addi(input logic [4:0] rd, input logic [4:0] ra);
        issue_valid_i   = 1'b1;
        issue_opcode_i  = {12'd1, ra, 3'd0, rd, 7'b0010011};
        issue_invalid_i = 1'b0;
        issue_rd_idx_i  = rd;
        issue_ra_idx_i  = ra;
        issue_rb_idx_i  = 5'd0;
    endtask

    task automatic idle();
        issue_valid_i   = 1'b0;
        issue_opcode_i  = 32'h0000_0013;
        issue_invalid_i = 1'b0;
        issue_rd_idx_i  = 5'd0;
        issue_ra_idx_i  = 5'd0;
        issue_rb_idx_i  = 5'd0;
    endtask

    // Inputs change 1ns after the edge, checks happen 2ns after the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i  = 1'b1;
        hold_i = 1'b0;
        idle();
        #12;
        settle();
        chk("rst_wb_valid", {31'd0, wb_valid_o}, 0);
        chk("rst_wb_rd", {27'd0, wb_rd_idx_o}, 0);
        chk("rst_inflight", {30'd0, inflight_o}, 0);
        chk("rst_stall", {31'd0, issue_stall_o}, 0);
        rst_i = 1'b0;

        // Basic latency: mul x3,x1,x2
        tick(); mul(5'd3, 5'd1, 5'd2); settle();
        chk("t1_mul_valid", {31'd0, mul_valid_o}, 1);
        chk("t1_stall", {31'd0, issue_stall_o}, 0);
        tick(); idle(); settle();
        chk("t1_wb_T1", {31'd0, wb_valid_o}, 0);
        chk("t1_inflight_T1", {30'd0, inflight_o}, 1);
        tick(); settle();
        chk("t1_wb_T2", {31'd0, wb_valid_o}, 1);
        chk("t1_wb_rd_T2", {27'd0, wb_rd_idx_o}, 3);
        tick(); settle();
        chk("t1_wb_T3", {31'd0, wb_valid_o}, 0);
        chk("t1_inflight_T3", {30'd0, inflight_o}, 0);

        // RAW: mul x3 then add x4,x3,x0
        tick(); mul(5'd3, 5'd1, 5'd2); settle();
        tick(); add(5'd4, 5'd3, 5'd0); settle();
        chk("raw_stall_T1", {31'd0, issue_stall_o}, 1);
        chk("raw_mulv_T1", {31'd0, mul_valid_o}, 0);
        tick(); settle();
`ifdef MUL_BYPASS_EN
        chk("raw_stall_T2", {31'd0, issue_stall_o}, 0);
        chk("raw_bypass_ra", {31'd0, bypass_ra_o}, 1);
        chk("raw_bypass_rb", {31'd0, bypass_rb_o}, 0);
`else
        chk("raw_stall_T2", {31'd0, issue_stall_o}, 1);
`endif
        tick(); settle();
        chk("raw_stall_T3", {31'd0, issue_stall_o}, 0);
        chk("raw_inflight_T3", {30'd0, inflight_o}, 0);

        // WAW: mul x7 then addi x7,x0,1
        tick(); mul(5'd7, 5'd1, 5'd2); settle();
        tick(); addi(5'd7, 5'd0); settle();
        chk("waw_stall_T1", {31'd0, issue_stall_o}, 1);
        tick(); settle();
        chk("waw_stall_T2", {31'd0, issue_stall_o}, 1);
        tick(); settle();
        chk("waw_stall_T3", {31'd0, issue_stall_o}, 0);

        // Four independent muls back to back
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k < 4) mul(5'(k + 1), 5'd10, 5'd11);
            else idle();
            settle();
            if (k < 4) begin
                chk("b2b_stall", {31'd0, issue_stall_o}, 0);
                chk("b2b_mulv", {31'd0, mul_valid_o}, 1);
            end
            chk("b2b_inflight", {30'd0, inflight_o},
                (k == 0 || k == 6) ? 0 : (k == 1 || k == 5) ? 1 : 2);
            chk("b2b_wb_valid", {31'd0, wb_valid_o}, (k >= 2 && k <= 5) ? 1 : 0);
            if (k >= 2 && k <= 5)
                chk("b2b_wb_rd", {27'd0, wb_rd_idx_o}, k - 1);
        end

        // rd=0 mul creates no entry; invalid mul never issues
        tick(); mul(5'd0, 5'd1, 5'd2); settle();
        chk("x0_mulv", {31'd0, mul_valid_o}, 1);
        tick(); add(5'd5, 5'd0, 5'd0); settle();
        chk("x0_stall", {31'd0, issue_stall_o}, 0);
        chk("x0_inflight", {30'd0, inflight_o}, 0);
        tick(); issue_r(7'h01, 3'd3, 5'd6, 5'd1, 5'd2, 1'b1); settle();
        chk("x0_wb_valid", {31'd0, wb_valid_o}, 0);
        chk("inv_mulv", {31'd0, mul_valid_o}, 0);
        tick(); idle(); settle();
        chk("inv_inflight", {30'd0, inflight_o}, 0);

        // Hold: mul x9 at T, hold through T+1..T+3
        tick(); issue_r(7'h01, 3'd1, 5'd9, 5'd1, 5'd2, 1'b0); settle();
        chk("hold_mulv_T", {31'd0, mul_valid_o}, 1);
        tick(); hold_i = 1'b1; mul(5'd20, 5'd10, 5'd11); settle();
        chk("hold_mulv_held", {31'd0, mul_valid_o}, 0);
        chk("hold_stall_free", {31'd0, issue_stall_o}, 0);
        tick(); add(5'd1, 5'd9, 5'd0); settle();
        chk("hold_stall_raw", {31'd0, issue_stall_o}, 1);
        tick(); idle(); settle();
        chk("hold_inflight", {30'd0, inflight_o}, 1);
        chk("hold_wb_T3", {31'd0, wb_valid_o}, 0);
        tick(); hold_i = 1'b0; settle();
        chk("hold_wb_T4", {31'd0, wb_valid_o}, 0);
        tick(); settle();
        chk("hold_wb_T5", {31'd0, wb_valid_o}, 1);
        chk("hold_wb_rd_T5", {27'd0, wb_rd_idx_o}, 9);
        tick(); settle();
        chk("hold_wb_T6", {31'd0, wb_valid_o}, 0);

        // Asynchronous reset with an entry in flight
        tick(); mul(5'd12, 5'd1, 5'd2); settle();
        tick(); add(5'd13, 5'd12, 5'd0); settle();
        chk("rst_pre_inflight", {30'd0, inflight_o}, 1);
        chk("rst_pre_stall", {31'd0, issue_stall_o}, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_mid_inflight", {30'd0, inflight_o}, 0);
        chk("rst_mid_stall", {31'd0, issue_stall_o}, 0);
        chk("rst_mid_wb", {31'd0, wb_valid_o}, 0);
        tick(); rst_i = 1'b0; idle(); settle();
        tick(); settle();
        chk("rst_post_wb", {31'd0, wb_valid_o}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
